batch_ram_ctrl: RTL

BATCH_RAM_CTRL -- requirements
Module: batch_ram_ctrl

---
 rtl/batch_ram_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/batch_ram_ctrl.sv
// batch_ram_ctrl: collects control-bit samples into a four-region RAM and,
// once three batches are present, sweeps the newest region (descending)
// alongside the two previous regions (ascending) as a stream of
// triple-sample beats.
module batch_ram_ctrl #(
  parameter int batch   = 8,
  parameter int d_width = 3
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [d_width-1:0]              in_data,
  output logic                            ram_write,
  output logic [$clog2(4*batch)-1:0]      ram_addrIn,
  output logic [d_width-1:0]              ram_dataIn,
  output logic [$clog2(4*batch)-1:0]      ram_addrOut1,
  output logic [$clog2(4*batch)-1:0]      ram_addrOut2,
  output logic [$clog2(4*batch)-1:0]      ram_addrOut3,
  input  logic [d_width-1:0]              ram_dataOut1,
  input  logic [d_width-1:0]              ram_dataOut2,
  input  logic [d_width-1:0]              ram_dataOut3,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [d_width-1:0]              out_data1,
  output logic [d_width-1:0]              out_data2,
  output logic [d_width-1:0]              out_data3,
  output logic                            out_first,
  output logic                            out_last
);

  localparam int BW = $clog2(batch);
  localparam logic [BW-1:0] KLAST = BW'(batch - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;

  logic [0:0]    state;
  logic [BW-1:0] wcnt;
  logic [BW-1:0] k;
  logic [1:0]    wreg;
  logic [1:0]    dreg;
  logic [1:0]    preg;
  logic [1:0]    filled;
  logic          pending;

  logic          accept;
  logic          complete;
  logic          request;
  logic          load;
  logic          last_load;
  logic          start;
  logic [1:0]    start_region;
  logic          pending_nxt;

  // Handshake, batch completion and sweep start decisions.
  always_comb begin
    accept       = in_valid && in_ready;
    complete     = accept && (wcnt == KLAST);
    request      = complete && (filled >= 2'd2);
    load         = (state == SWEEP) && (!out_valid || out_ready);
    last_load    = load && (k == KLAST);
    // A sweep starts from IDLE or back-to-back after the last beat loads.
    start        = (request || pending) && ((state == IDLE) || last_load);
    start_region = request ? wreg : preg;
    pending_nxt  = pending;
    if (start)
      pending_nxt = 1'b0;
    else if (request)
      pending_nxt = 1'b1;
  end

  assign ram_write    = accept;
  assign ram_dataIn   = in_data;
  assign ram_addrIn   = {wreg, wcnt};
  // batch-1-k equals ~k because batch is a power of two.
  assign ram_addrOut1 = {dreg, ~k};
  assign ram_addrOut2 = {dreg - 2'd1, k};
  assign ram_addrOut3 = {dreg - 2'd2, k};

  // Write pointer and count of filled regions.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wcnt   <= '0;
      wreg   <= '0;
      filled <= '0;
    end else if (accept) begin
      wcnt <= wcnt + BW'(1);
      if (complete) begin
        wreg <= wreg + 2'd1;
        if (filled != 2'd3)
          filled <= filled + 2'd1;
      end
    end
  end

  // Sweep sequencing, pending request and input back-pressure.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      k        <= '0;
      dreg     <= '0;
      preg     <= '0;
      pending  <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      if (start) begin
        state <= SWEEP;
        dreg  <= start_region;
        k     <= '0;
      end else if (last_load) begin
        state <= IDLE;
        k     <= '0;
      end else if (load) begin
        k <= k + BW'(1);
      end
      if (!start && request)
        preg <= wreg;
      pending  <= pending_nxt;
      in_ready <= !pending_nxt;
    end
  end

  // Output beat register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_data1 <= '0;
      out_data2 <= '0;
      out_data3 <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_first <= (k == '0);
      out_last  <= (k == KLAST);
      out_data1 <= ram_dataOut1;
      out_data2 <= ram_dataOut2;
      out_data3 <= ram_dataOut3;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
